dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Two-master arbiter and sequencer for the single-ported data memory.
- Master 0 is the CPU MEM stage; master 1 is the debug/DMA loader.
- Each transaction is latched, checked for legal address and byte-enable, issued to the DM for exactly one cycle, then acknowledged with registered read data.
- Sits between the pipeline/bridge and the DM instance; owns dm_memw_enable, dm_byteen, dm_adr and dm_write.

Parameters:
- ADDR_W, 14: byte-address bits decoded by the DM. Legal only if addr[31:ADDR_W]==0.
- FIRST_PRIO, 0: master that wins the first tie after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 request; held until m0_ack
- m0_we  in  1  1=write, 0=read
- m0_byteen  in  4  byte enable; legal: 1111, 1100, 0011, 1000, 0100, 0010, 0001
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data, right-aligned (low bits used for half/byte)
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  valid with m0_ack; 1 = rejected access
- m0_rdata  out  32  read data, valid with m0_ack
- m1_req, m1_we, m1_byteen, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as master 0
- dm_memw_enable  out  1  DM write strobe
- dm_byteen  out  4  to DM
- dm_adr  out  32  to DM
- dm_write  out  32  to DM
- dm_read  in  32  DM combinational read data (right-aligned, zero-extended)
- busy  out  1  1 when state != IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset outputs: state=IDLE; all m*_ack, m*_err, m*_rdata = 0; dm_* = 0; busy=0; last-served register = ~FIRST_PRIO.
- dm_memw_enable is additionally gated by !reset, so no write occurs in a reset cycle.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant it.
  - Both req: grant the master not last served (round-robin).
  - At the edge: latch grant, we, byteen, addr, wdata; compute err; update last-served; go to ACCESS.
- Legality check, computed at latch:
  - Illegal if addr[31:ADDR_W]!=0.
  - Illegal if byteen is not in the legal set.
  - Illegal on misalignment:
    - 1111 requires addr[1:0]=00.
    - 1100 requires addr[1:0]=10; 0011 requires addr[1:0]=00.
    - A single-byte enable requires bit index == addr[1:0].
- ACCESS (one cycle):
  - dm_adr, dm_byteen and dm_write are driven from the latched fields.
  - dm_memw_enable = latched we & !err.
  - For a legal read, dm_read is captured at the edge into the rdata register; otherwise rdata is captured as 0.
  - Go to RESP.
- RESP (one cycle):
  - Granted master's ack=1, err=latched err, rdata=captured value.
  - The other master's outputs stay 0.
  - Go to IDLE. No arbitration happens in RESP.
- Outside RESP: ack=0, err=0, rdata=0. dm_* = 0 except during ACCESS.
- Latency: req sampled in IDLE at edge N; DM access in cycle N+1; ack in cycle N+2. Peak rate is 1 transaction per 3 cycles.
- Requester protocol: req and fields must stay stable until ack. A req drop after the latch edge is ignored; the transaction completes and ack is still pulsed. A req still high in the IDLE cycle after ack is a new transaction.
- Fairness: under continuous dual requests, grants alternate 0, 1, 0, 1, ...
- Reset mid-operation: any state returns to IDLE. A pending transaction is dropped with no ack and no DM write.
- No internal storage beyond the latch and rdata registers. Byte/half sign extension stays in the CPU.

Test Plan:
- Reset, then m0 write word 0x12345678 @0x00000010, byteen 1111 -> dm_memw_enable=1 only in cycle 2; m0_ack=1, m0_err=0 in cycle 3. A following m0 read of 0x10 returns m0_rdata=0x12345678.
- m0 and m1 both req reads in the same cycle after reset, FIRST_PRIO=0 -> m0 acked first. m1 is granted at the next IDLE and acked 3 cycles after m0's ack. Repeat continuously -> strict alternation.
- m1 byte write 0xAB, byteen 0100 @0x22 -> DM word 0x20 bits [23:16]=0xAB. A read with byteen 0100 returns 0x000000AB.
- Illegal accesses -> err=1 with ack, no DM write, rdata=0:
  - byteen 0110 @0x0
  - byteen 1111 @0x2
  - addr 0x00004000 with byteen 1111
- reset asserted during ACCESS of a write -> dm_memw_enable=0 that cycle, no ack issued, busy=0 next cycle, DM contents unchanged.
- m0 drops req during ACCESS -> ack still pulses next cycle. m0 holds req high after ack -> a new transaction starts.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Two-master arbiter and sequencer for the single-ported data memory.
// Master 0 is the CPU MEM stage and master 1 is the debug/DMA loader.
// The arbiter latches one transaction and checks it for legality.
// It then drives the DM for a single cycle and returns a registered response.
module dm_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_byteen,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_byteen,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        dm_memw_enable,
  output logic [3:0]  dm_byteen,
  output logic [31:0] dm_adr,
  output logic [31:0] dm_write,
  input  logic [31:0] dm_read,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_served;
  logic        gnt_q;
  logic        we_q;
  logic        err_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        any_req;
  logic        gnt_sel;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // An access is rejected when it lies outside the DM or when its byte enable is unknown.
  // It is also rejected when the byte enable does not match the byte offset of the address.
  function automatic logic is_illegal(input logic [31:0] addr, input logic [3:0] be);
    logic bad;
    bad = ((addr >> ADDR_W) != 32'd0);
    case (be)
      4'b1111: bad = bad | (addr[1:0] != 2'b00);
      4'b1100: bad = bad | (addr[1:0] != 2'b10);
      4'b0011: bad = bad | (addr[1:0] != 2'b00);
      4'b1000: bad = bad | (addr[1:0] != 2'b11);
      4'b0100: bad = bad | (addr[1:0] != 2'b10);
      4'b0010: bad = bad | (addr[1:0] != 2'b01);
      4'b0001: bad = bad | (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Round-robin pick: a lone requester wins, and a tie goes to the master not served last.
  always_comb begin
    any_req = m0_req | m1_req;
    gnt_sel = 1'b0;
    if (m0_req && m1_req) begin
      gnt_sel = ~last_served;
    end else if (m1_req) begin
      gnt_sel = 1'b1;
    end
    sel_we    = gnt_sel ? m1_we     : m0_we;
    sel_be    = gnt_sel ? m1_byteen : m0_byteen;
    sel_addr  = gnt_sel ? m1_addr   : m0_addr;
    sel_wdata = gnt_sel ? m1_wdata  : m0_wdata;
  end

  // State register, transaction latch and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_served <= ~FIRST_PRIO;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      be_q        <= 4'b0000;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q       <= gnt_sel;
            we_q        <= sel_we;
            be_q        <= sel_be;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            err_q       <= is_illegal(sel_addr, sel_be);
            last_served <= gnt_sel;
          end
        end
        ACCESS: begin
          rdata_q <= (!we_q && !err_q) ? dm_read : 32'd0;
        end
        default: begin
        end
      endcase
    end
  end

  // Next state: IDLE waits for a request, then moves through one ACCESS cycle and one RESP cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_req ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: the DM is driven only in ACCESS, and the granted master sees its response only in RESP.
  always_comb begin
    dm_memw_enable = 1'b0;
    dm_byteen      = 4'b0000;
    dm_adr         = 32'd0;
    dm_write       = 32'd0;
    m0_ack         = 1'b0;
    m0_err         = 1'b0;
    m0_rdata       = 32'd0;
    m1_ack         = 1'b0;
    m1_err         = 1'b0;
    m1_rdata       = 32'd0;
    busy           = (state_q != IDLE);
    case (state_q)
      ACCESS: begin
        dm_memw_enable = we_q & ~err_q & ~reset;
        dm_byteen      = be_q;
        dm_adr         = addr_q;
        dm_write       = wdata_q;
      end
      RESP: begin
        if (gnt_q) begin
          m1_ack   = 1'b1;
          m1_err   = err_q;
          m1_rdata = rdata_q;
        end else begin
          m0_ack   = 1'b1;
          m0_err   = err_q;
          m0_rdata = rdata_q;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter.
// The bench contains a behavioural DM, a response scoreboard, a vector table and hand-written corner sequences.
module tb_dm_port_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_byteen, m1_byteen;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dm_memw_enable;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_adr, dm_write, dm_read;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_count = 0;
  int dm_wr_count = 0;

  typedef struct {
    bit          master;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    bit          master;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[19];

  logic [31:0] mem [0:4095] = '{default: 32'd0};

  dm_port_arbiter #(.ADDR_W(14), .FIRST_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_byteen(m0_byteen), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_byteen(m1_byteen), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .dm_memw_enable(dm_memw_enable), .dm_byteen(dm_byteen), .dm_adr(dm_adr),
    .dm_write(dm_write), .dm_read(dm_read), .busy(busy)
  );

  // Free-running clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int low_lane(input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Behavioural DM: right-aligned data is shifted into its lane on write and back down on read.
  always @(posedge clk) begin
    if (dm_memw_enable) begin
      mem[dm_adr[13:2]] <= (mem[dm_adr[13:2]] & ~lane_mask(dm_byteen)) |
                           ((dm_write << (8 * low_lane(dm_byteen))) & lane_mask(dm_byteen));
      dm_wr_count <= dm_wr_count + 1;
    end
  end

  always_comb begin
    dm_read = (mem[dm_adr[13:2]] & lane_mask(dm_byteen)) >> (8 * low_lane(dm_byteen));
  end

  // Response monitor: each ack is matched against the oldest expectation, and all response outputs must be quiet when there is no ack.
  always @(negedge clk) begin
    exp_t e;
    bit          got_m;
    bit          got_err;
    logic [31:0] got_rd;
    if (m0_ack === 1'b1 && m1_ack === 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL both_ack: got m0_ack=1 m1_ack=1 expected at most one");
    end else if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
      got_m   = (m1_ack === 1'b1);
      got_err = got_m ? m1_err : m0_err;
      got_rd  = got_m ? m1_rdata : m0_rdata;
      checks++;
      ack_count++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_ack: got ack from m%0d expected none", got_m);
      end else begin
        e = sb.pop_front();
        if (got_m != e.master || got_err !== e.err || got_rd !== e.rdata ||
            (got_m ? (m0_err !== 1'b0 || m0_rdata !== 32'd0)
                   : (m1_err !== 1'b0 || m1_rdata !== 32'd0))) begin
          errors++;
          $display("[TB] FAIL response: got m%0d err=%0d rdata=0x%08h expected m%0d err=%0d rdata=0x%08h",
                   got_m, got_err, got_rd, e.master, e.err, e.rdata);
        end
      end
    end else begin
      checks++;
      if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_err !== 1'b0 || m1_err !== 1'b0 ||
          m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin
        errors++;
        $display("[TB] FAIL quiet_outputs: got err=%b%b rdata=0x%08h/0x%08h expected all 0",
                 m0_err, m1_err, m0_rdata, m1_rdata);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit m, input bit we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (m) begin
      m1_we = we; m1_byteen = be; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end else begin
      m0_we = we; m0_byteen = be; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end
  endtask

  task automatic push_exp(input bit m, input bit err, input logic [31:0] rdata);
    exp_t e;
    e.master = m; e.err = err; e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input bit m);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if ((m ? m1_ack : m0_ack) === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout: got no ack from m%0d expected ack within 12 cycles", m);
    end
  endtask

  task automatic run_txn(input vec_t v);
    @(posedge clk); #1;
    push_exp(v.master, v.exp_err, v.exp_rdata);
    applyStimulus(v.master, v.we, v.be, v.addr, v.wdata);
    wait_ack(v.master);
    if (v.master) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int wc0;
    int nacks;
    int prev_ack;
    int legal_writes;
    vec_t v;

    vecs[0]  = '{0, 0, 4'b1111, 32'h0000_0010, 32'h0,         0, 32'h1234_5678};
    vecs[1]  = '{1, 1, 4'b0100, 32'h0000_0022, 32'h0000_00AB, 0, 32'h0};
    vecs[2]  = '{1, 0, 4'b0100, 32'h0000_0022, 32'h0,         0, 32'h0000_00AB};
    vecs[3]  = '{0, 0, 4'b1111, 32'h0000_0020, 32'h0,         0, 32'h00AB_0000};
    vecs[4]  = '{0, 1, 4'b0110, 32'h0000_0000, 32'hFFFF_FFFF, 1, 32'h0};
    vecs[5]  = '{0, 1, 4'b1111, 32'h0000_0002, 32'hFFFF_FFFF, 1, 32'h0};
    vecs[6]  = '{0, 1, 4'b1111, 32'h0000_4000, 32'hFFFF_FFFF, 1, 32'h0};
    vecs[7]  = '{1, 0, 4'b1111, 32'h0000_0000, 32'h0,         0, 32'h0};
    vecs[8]  = '{1, 1, 4'b0011, 32'h0000_0030, 32'h0000_BEEF, 0, 32'h0};
    vecs[9]  = '{0, 1, 4'b1100, 32'h0000_0032, 32'h0000_CAFE, 0, 32'h0};
    vecs[10] = '{1, 0, 4'b1111, 32'h0000_0030, 32'h0,         0, 32'hCAFE_BEEF};
    vecs[11] = '{0, 0, 4'b1100, 32'h0000_0030, 32'h0,         1, 32'h0};
    vecs[12] = '{0, 0, 4'b0001, 32'h0000_0031, 32'h0,         1, 32'h0};
    vecs[13] = '{0, 0, 4'b0010, 32'h0000_0031, 32'h0,         0, 32'h0000_00BE};
    vecs[14] = '{1, 0, 4'b1111, 32'h0000_4030, 32'h0,         1, 32'h0};
    vecs[15] = '{1, 0, 4'b0000, 32'h0000_0030, 32'h0,         1, 32'h0};
    vecs[16] = '{0, 0, 4'b1000, 32'h0000_0033, 32'h0,         0, 32'h0000_00CA};
    vecs[17] = '{1, 1, 4'b1111, 32'h8000_0010, 32'h0BAD_0BAD, 1, 32'h0};
    vecs[18] = '{0, 0, 4'b1111, 32'h0000_0010, 32'h0,         0, 32'h1234_5678};

    m0_we = 0; m0_byteen = 0; m0_addr = 0; m0_wdata = 0;
    m1_we = 0; m1_byteen = 0; m1_addr = 0; m1_wdata = 0;
    do_reset();

    // Reset state
    @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_dm_we", {31'd0, dm_memw_enable}, 32'd0);
    checkOutput("reset_dm_adr", dm_adr, 32'd0);
    checkOutput("reset_dm_write", dm_write, 32'd0);
    checkOutput("reset_dm_byteen", {28'd0, dm_byteen}, 32'd0);

    // Cycle-exact word write: DM strobe in cycle 2, ack in cycle 3
    @(posedge clk); #1;
    push_exp(0, 0, 32'h0);
    applyStimulus(0, 1, 4'b1111, 32'h0000_0010, 32'h1234_5678);
    @(negedge clk);
    checkOutput("c1_dm_we", {31'd0, dm_memw_enable}, 32'd0);
    @(negedge clk);
    checkOutput("c2_dm_we", {31'd0, dm_memw_enable}, 32'd1);
    checkOutput("c2_dm_adr", dm_adr, 32'h0000_0010);
    checkOutput("c2_dm_write", dm_write, 32'h1234_5678);
    checkOutput("c2_dm_byteen", {28'd0, dm_byteen}, 32'h0000_000F);
    checkOutput("c2_busy", {31'd0, busy}, 32'd1);
    checkOutput("c2_m0_ack", {31'd0, m0_ack}, 32'd0);
    @(negedge clk);
    checkOutput("c3_m0_ack", {31'd0, m0_ack}, 32'd1);
    checkOutput("c3_dm_we", {31'd0, dm_memw_enable}, 32'd0);
    checkOutput("c3_dm_adr", dm_adr, 32'd0);
    m0_req = 1'b0;
    @(negedge clk);
    checkOutput("c4_busy", {31'd0, busy}, 32'd0);

    // Vector table
    wc0 = dm_wr_count;
    legal_writes = 0;
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].we && !vecs[i].exp_err) legal_writes++;
      run_txn(vecs[i]);
    end
    @(negedge clk);
    checkOutput("table_dm_writes", dm_wr_count - wc0, legal_writes);

    // Round-robin under continuous dual requests after reset
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) push_exp(i[0], 0, i[0] ? 32'h00AB_0000 : 32'h1234_5678);
    applyStimulus(0, 0, 4'b1111, 32'h0000_0010, 32'h0);
    applyStimulus(1, 0, 4'b1111, 32'h0000_0020, 32'h0);
    nacks = 0;
    prev_ack = 0;
    for (int k = 0; k < 40 && nacks < 6; k++) begin
      @(negedge clk);
      if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
        if (nacks > 0) checkOutput("rr_ack_spacing", cyc - prev_ack, 32'd3);
        prev_ack = cyc;
        nacks++;
        if (nacks == 6) begin
          m0_req = 1'b0;
          m1_req = 1'b0;
        end
      end
    end
    checkOutput("rr_ack_total", nacks, 32'd6);
    m0_req = 1'b0;
    m1_req = 1'b0;

    // Request dropped during ACCESS still completes
    @(posedge clk); #1;
    push_exp(0, 0, 32'h1234_5678);
    applyStimulus(0, 0, 4'b1111, 32'h0000_0010, 32'h0);
    @(posedge clk); #1;
    m0_req = 1'b0;
    wait_ack(0);

    // Request held through ack starts a second transaction
    @(posedge clk); #1;
    push_exp(0, 0, 32'h1234_5678);
    push_exp(0, 0, 32'h1234_5678);
    applyStimulus(0, 0, 4'b1111, 32'h0000_0010, 32'h0);
    wait_ack(0);
    wait_ack(0);
    m0_req = 1'b0;

    // Reset during ACCESS of a write drops the transaction
    wc0 = dm_wr_count;
    @(posedge clk); #1;
    applyStimulus(0, 1, 4'b1111, 32'h0000_0040, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    reset = 1'b1;
    m0_req = 1'b0;
    @(negedge clk);
    checkOutput("rst_access_dm_we", {31'd0, dm_memw_enable}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_access_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("rst_access_dm_writes", dm_wr_count - wc0, 32'd0);
    v = '{0, 0, 4'b1111, 32'h0000_0040, 32'h0, 0, 32'h0};
    run_txn(v);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
